mrd_source_rd: RTL and testbench

//  Source (unload) stage of the Mixed Radix DFT memory. After the last butterfly stage, it reads the
//  7 RAM banks in natural order k=0..dftpts-1. Bank k mod 7 holds point k at bank address k/7.

---
 rtl/mrd_pkg.sv | 49 ++++
 rtl/mrd_src_fifo.sv | 57 +++++
 rtl/mrd_source_rd.sv | 168 ++++++++++++++++
 tb/tb_mrd_source_rd.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mrd_pkg.sv
// Shared definitions for the Mixed Radix DFT memory source (unload) stage.
//   N_BANK, wD, wOut, wA : bank count and data/address widths
//   src_state_t          : unload FSM states
//   src_word_t           : one output word (rounded real/imag plus framing tags)
//   sat_round            : round-half-up right shift followed by saturation to wOut bits
package mrd_pkg;

    localparam int N_BANK = 7;
    localparam int wD     = 30;
    localparam int wOut   = 18;
    localparam int wA     = 8;

    localparam int SAT_MAX = (1 << (wOut - 1)) - 1;
    localparam int SAT_MIN = -(1 << (wOut - 1));

    typedef enum logic [1:0] {
        SRC_IDLE,
        SRC_READ,
        SRC_DRAIN
    } src_state_t;

    // "real" is a keyword, hence re/im.
    typedef struct packed {
        logic signed [wOut-1:0] re;
        logic signed [wOut-1:0] im;
        logic                   sop;
        logic                   eop;
    } src_word_t;

    // One guard bit above wD keeps d + rounding constant from wrapping.
    function automatic logic signed [wOut-1:0] sat_round(input logic signed [wD-1:0] d,
                                                         input logic [3:0]          shift);
        logic signed [wD:0] ext;
        logic signed [wD:0] rnd;
        logic signed [wD:0] y;
        ext = {d[wD-1], d};
        rnd = '0;
        if (shift != 4'd0)
            rnd = (wD+1)'(1) << (shift - 4'd1);
        y = (ext + rnd) >>> shift;
        if (y > (wD+1)'(SAT_MAX))
            return wOut'(SAT_MAX);
        else if (y < (wD+1)'(SAT_MIN))
            return wOut'(SAT_MIN);
        else
            return y[wOut-1:0];
    endfunction

endpackage

// File: rtl/mrd_src_fifo.sv
// Skid FIFO holding rounded output words until downstream accepts them.
//   clk, rst : clock, asynchronous active-high reset (pointers/count only)
//   push/din : write a word (ignored when full unless a pop happens the same cycle)
//   pop/dout : dout is the head word; pop removes it (ignored when empty)
//   count    : number of stored words
//   empty    : count == 0
module mrd_src_fifo
    import mrd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  src_word_t     din,
    input  logic          pop,
    output src_word_t     dout,
    output logic [CW-1:0] count,
    output logic          empty
);

    src_word_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mrd_source_rd.sv
// Source (unload) stage of the Mixed Radix DFT memory. Reads points k=0..dftpts-1 from the
// 7 banks (bank k mod 7, address k/7), rounds/saturates each to wOut bits and streams them out.
//   clk, rst             : clock, asynchronous active-high reset
//   start, dftpts, shift : run request; dftpts and shift latched when start is accepted
//   rden, rdaddr         : per-bank read strobe (one-hot or zero) and address
//   d_real_rd, d_imag_rd : bank read data, valid RD_LAT cycles after rden
//   out_valid/out_ready  : output handshake; out_sop/out_eop frame the run
//   out_real, out_imag   : rounded, saturated sample
//   busy, done           : run in progress; 1-cycle pulse after the eop handshake
module mrd_source_rd
    import mrd_pkg::*;
#(
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [11:0]                      dftpts,
    input  logic [3:0]                       shift,
    output logic [0:N_BANK-1]                rden,
    output logic [0:N_BANK-1][wA-1:0]        rdaddr,
    input  logic [0:N_BANK-1][wD-1:0]        d_real_rd,
    input  logic [0:N_BANK-1][wD-1:0]        d_imag_rd,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_sop,
    output logic                             out_eop,
    output logic signed [wOut-1:0]           out_real,
    output logic signed [wOut-1:0]           out_imag,
    output logic                             busy,
    output logic                             done
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    src_state_t       state;
    src_state_t       state_nxt;
    logic [11:0]      dftpts_r;
    logic [3:0]       shift_r;
    logic [11:0]      k_cnt;
    logic [2:0]       bank_idx;
    logic [wA-1:0]    bank_addr;
    logic             accept;
    logic             issue;
    logic             last_issue;
    int               inflight;

    logic [RD_LAT:1]        vld_p;
    logic [RD_LAT:1][2:0]   bank_p;
    logic [RD_LAT:1]        sop_p;
    logic [RD_LAT:1]        eop_p;

    logic [CW-1:0]    fifo_count;
    logic             fifo_empty;
    logic             pop;
    src_word_t        push_word;
    src_word_t        head;

    assign accept = (state == SRC_IDLE) && start && (dftpts != 12'd0);

    // Reads already issued but not yet in the FIFO still need a slot.
    always_comb begin
        inflight = 0;
        for (int i = 1; i <= RD_LAT; i++)
            inflight = inflight + int'(vld_p[i]);
    end

    assign issue      = (state == SRC_READ) && ((int'(fifo_count) + inflight) < FIFO_DEPTH);
    assign last_issue = issue && (k_cnt == dftpts_r - 12'd1);
    assign pop        = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            SRC_IDLE:  if (accept)             state_nxt = SRC_READ;
            SRC_READ:  if (last_issue)         state_nxt = SRC_DRAIN;
            SRC_DRAIN: if (pop && head.eop)    state_nxt = SRC_IDLE;
            default:                           state_nxt = SRC_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SRC_IDLE;
            dftpts_r  <= '0;
            shift_r   <= '0;
            k_cnt     <= '0;
            bank_idx  <= '0;
            bank_addr <= '0;
            done      <= 1'b0;
            vld_p     <= '0;
        end else begin
            state <= state_nxt;
            done  <= (state == SRC_DRAIN) && pop && head.eop;
            if (accept) begin
                dftpts_r  <= dftpts;
                shift_r   <= shift;
                k_cnt     <= '0;
                bank_idx  <= '0;
                bank_addr <= '0;
            end else if (issue) begin
                k_cnt <= k_cnt + 12'd1;
                // Walking bank/address pair replaces k/7 and k mod 7.
                if (bank_idx == 3'(N_BANK - 1)) begin
                    bank_idx  <= '0;
                    bank_addr <= bank_addr + 1'b1;
                end else begin
                    bank_idx  <= bank_idx + 3'd1;
                end
            end
            vld_p[1] <= issue;
            for (int i = 2; i <= RD_LAT; i++)
                vld_p[i] <= vld_p[i-1];
        end
    end

    always_comb begin
        rden   = '0;
        rdaddr = '0;
        if (issue) begin
            rden[bank_idx]   = 1'b1;
            rdaddr[bank_idx] = bank_addr;
        end
    end

    // ---- stage p1..pRD_LAT: read tags travel alongside the bank latency ----
    always_ff @(posedge clk) begin
        bank_p[1] <= bank_idx;
        sop_p[1]  <= (k_cnt == 12'd0);
        eop_p[1]  <= (k_cnt == dftpts_r - 12'd1);
        for (int i = 2; i <= RD_LAT; i++) begin
            bank_p[i] <= bank_p[i-1];
            sop_p[i]  <= sop_p[i-1];
            eop_p[i]  <= eop_p[i-1];
        end
    end

    // ---- return stage: select tagged bank, round/saturate, push into FIFO ----
    always_comb begin
        push_word.re  = sat_round(d_real_rd[bank_p[RD_LAT]], shift_r);
        push_word.im  = sat_round(d_imag_rd[bank_p[RD_LAT]], shift_r);
        push_word.sop = sop_p[RD_LAT];
        push_word.eop = eop_p[RD_LAT];
    end

    mrd_src_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (vld_p[RD_LAT]),
        .din   (push_word),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    // ---- output stage: FIFO head; data forced to 0 when nothing is valid ----
    assign out_valid = !fifo_empty;
    assign out_real  = out_valid ? head.re  : '0;
    assign out_imag  = out_valid ? head.im  : '0;
    assign out_sop   = out_valid && head.sop;
    assign out_eop   = out_valid && head.eop;
    assign busy      = (state != SRC_IDLE);

endmodule

// File: tb/tb_mrd_source_rd.sv
module tb_mrd_source_rd;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [11:0]        dftpts = '0;
    logic [3:0]         shift = '0;
    logic [0:6]         rden;
    logic [0:6][7:0]    rdaddr;
    logic [0:6][29:0]   d_real_rd;
    logic [0:6][29:0]   d_imag_rd;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic               out_sop;
    logic               out_eop;
    logic signed [17:0] out_real;
    logic signed [17:0] out_imag;
    logic               busy;
    logic               done;

    int n_cmp  = 0;
    int n_fail = 0;

    // bank memory contents indexed by point k, and expected outputs per k
    logic signed [29:0] mem_re [0:1199];
    logic signed [29:0] mem_im [0:1199];
    logic signed [17:0] exp_re [0:1199];
    logic signed [17:0] exp_im [0:1199];

    // monitor state (written only by the monitor process)
    logic signed [17:0] samp_re[$];
    logic signed [17:0] samp_im[$];
    logic               samp_sop[$];
    logic               samp_eop[$];
    int                 samp_cyc[$];
    int                 rd_bank[$];
    int                 rd_addr[$];
    int                 rd_bad = 0;
    int                 stall_bad = 0;
    int                 done_cnt = 0;
    int                 outstanding = 0;
    int                 max_out = 0;
    int                 cyc = 0;

    mrd_source_rd dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dftpts    (dftpts),
        .shift     (shift),
        .rden      (rden),
        .rdaddr    (rdaddr),
        .d_real_rd (d_real_rd),
        .d_imag_rd (d_imag_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // bank RAM model, one cycle read latency
    always @(posedge clk) begin
        for (int b = 0; b < 7; b++) begin
            if (rden[b]) begin
                d_real_rd[b] <= mem_re[(int'(rdaddr[b]) * 7 + b) % 1200];
                d_imag_rd[b] <= mem_im[(int'(rdaddr[b]) * 7 + b) % 1200];
            end
        end
    end

    // monitor on the falling edge
    initial begin
        logic        prev_stall;
        logic [37:0] prev_word;
        logic [37:0] cur_word;
        prev_stall = 1'b0;
        prev_word  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                outstanding = 0;
                prev_stall  = 1'b0;
            end else begin
                if (rden != 7'd0) begin
                    if (!$onehot(rden)) rd_bad++;
                    for (int b = 0; b < 7; b++) begin
                        if (rden[b]) begin
                            rd_bank.push_back(b);
                            rd_addr.push_back(int'(rdaddr[b]));
                        end
                    end
                end
                for (int b = 0; b < 7; b++)
                    if (!rden[b] && rdaddr[b] != 8'd0) rd_bad++;
                cur_word = {out_real, out_imag, out_sop, out_eop};
                if (prev_stall && (!out_valid || cur_word != prev_word)) stall_bad++;
                prev_stall = out_valid && !out_ready;
                prev_word  = cur_word;
                if (out_valid && out_ready) begin
                    samp_re.push_back(out_real);
                    samp_im.push_back(out_imag);
                    samp_sop.push_back(out_sop);
                    samp_eop.push_back(out_eop);
                    samp_cyc.push_back(cyc);
                end
                outstanding = outstanding + ((rden != 7'd0) ? 1 : 0)
                                          - ((out_valid && out_ready) ? 1 : 0);
                if (outstanding > max_out) max_out = outstanding;
                if (done) done_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 500000", $time);
        $fatal(1);
    end

    task automatic fill_ramp();
        for (int k = 0; k < 1200; k++) begin
            mem_re[k] = 30'(k);
            mem_im[k] = -30'(k);
            exp_re[k] = 18'(k);
            exp_im[k] = -18'(k);
        end
    endtask

    task automatic fill_zero();
        for (int k = 0; k < 1200; k++) begin
            mem_re[k] = '0;
            mem_im[k] = '0;
            exp_re[k] = '0;
            exp_im[k] = '0;
        end
    endtask

    task automatic start_run(input int n, input int sh);
        @(posedge clk); #1;
        start  = 1'b1;
        dftpts = 12'(n);
        shift  = 4'(sh);
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(input int ready_mode, input int max_cyc, input string name);
        int c;
        int d0;
        c  = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && c < max_cyc) begin
            out_ready = (ready_mode == 0) ? 1'b1 : ((c % 3) == 0);
            @(posedge clk); #1;
            c++;
        end
        out_ready = 1'b1;
        n_cmp++;
        if (done_cnt == d0) begin
            n_fail++;
            $display("FAIL %s_done_timeout: got no done after %0d cycles, required done", name, c);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_samples(input int base, input int n, input string name);
        n_cmp++;
        if (samp_re.size() - base != n) begin
            n_fail++;
            $display("FAIL %s_count: got %0d samples, required %0d", name, samp_re.size() - base, n);
        end
        for (int k = 0; k < n; k++) begin
            if (base + k < samp_re.size()) begin
                n_cmp++;
                if (samp_re[base+k] !== exp_re[k] || samp_im[base+k] !== exp_im[k] ||
                    samp_sop[base+k] !== (k == 0) || samp_eop[base+k] !== (k == n - 1)) begin
                    n_fail++;
                    $display("FAIL %s_sample k=%0d: got re=%0d im=%0d sop=%0b eop=%0b, required re=%0d im=%0d sop=%0b eop=%0b",
                             name, k, samp_re[base+k], samp_im[base+k], samp_sop[base+k], samp_eop[base+k],
                             exp_re[k], exp_im[k], (k == 0), (k == n - 1));
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, out_sop, out_eop, busy, done, rden} !== 12'd0 || out_real !== 18'sd0 ||
            out_imag !== 18'sd0 || rdaddr !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%0b busy=%0b done=%0b rden=%b re=%0d, required all 0",
                     out_valid, busy, done, rden, out_real);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int base;
        int rbase;
        int d0;
        int bad0;
        fill_ramp();
        base  = samp_re.size();
        rbase = rd_bank.size();
        d0    = done_cnt;
        bad0  = rd_bad;
        out_ready = 1'b1;
        start_run(12, 0);
        n_cmp++;
        if (rden !== 7'b1000000 || rdaddr[0] !== 8'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_first_read: got rden=%b addr0=%0d busy=%0b, required rden=1000000 addr0=0 busy=1",
                     rden, rdaddr[0], busy);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latency_early: got out_valid=%0b, required 0", out_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_sop !== 1'b1 || out_real !== 18'sd0) begin
            n_fail++;
            $display("FAIL basic_first_valid: got valid=%0b sop=%0b re=%0d, required valid=1 sop=1 re=0",
                     out_valid, out_sop, out_real);
        end
        wait_done(0, 100, "basic");
        check_samples(base, 12, "basic");
        n_cmp++;
        if (rd_bank.size() - rbase != 12) begin
            n_fail++;
            $display("FAIL basic_read_count: got %0d reads, required 12", rd_bank.size() - rbase);
        end
        for (int k = 0; k < 12; k++) begin
            if (rbase + k < rd_bank.size()) begin
                n_cmp++;
                if (rd_bank[rbase+k] != k % 7 || rd_addr[rbase+k] != k / 7) begin
                    n_fail++;
                    $display("FAIL basic_read_seq k=%0d: got bank=%0d addr=%0d, required bank=%0d addr=%0d",
                             k, rd_bank[rbase+k], rd_addr[rbase+k], k % 7, k / 7);
                end
            end
        end
        n_cmp++;
        if (rd_bad != bad0) begin
            n_fail++;
            $display("FAIL basic_rden_shape: got %0d bad read cycles, required 0", rd_bad - bad0);
        end
        n_cmp++;
        if (samp_re.size() - base == 12 && samp_cyc[base+11] - samp_cyc[base] != 11) begin
            n_fail++;
            $display("FAIL basic_throughput: got %0d cycles for 12 samples, required 11",
                     samp_cyc[base+11] - samp_cyc[base]);
        end
        n_cmp++;
        if (done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL basic_done_count: got %0d, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_backpressure();
        int base;
        int d0;
        int s0;
        fill_ramp();
        base = samp_re.size();
        d0   = done_cnt;
        s0   = stall_bad;
        start_run(60, 0);
        wait_done(1, 400, "bp");
        check_samples(base, 60, "bp");
        n_cmp++;
        if (stall_bad != s0) begin
            n_fail++;
            $display("FAIL bp_stable: got %0d unstable stall cycles, required 0", stall_bad - s0);
        end
        n_cmp++;
        if (max_out > 4) begin
            n_fail++;
            $display("FAIL bp_inflight: got max outstanding %0d, required <= 4", max_out);
        end
        n_cmp++;
        if (done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL bp_done_count: got %0d, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_arith();
        int base;
        // shift = 2: round half up
        fill_zero();
        mem_re[0] = 30'sd6;   exp_re[0] = 18'sd2;   exp_im[0] = -18'sd1;
        mem_re[1] = -30'sd6;  exp_re[1] = -18'sd1;  exp_im[1] = 18'sd2;
        mem_re[2] = 30'sd5;   exp_re[2] = 18'sd1;   exp_im[2] = -18'sd1;
        mem_re[3] = -30'sd5;  exp_re[3] = -18'sd1;  exp_im[3] = 18'sd1;
        mem_re[4] = 30'sd7;   exp_re[4] = 18'sd2;   exp_im[4] = -18'sd2;
        mem_re[5] = -30'sd7;  exp_re[5] = -18'sd2;  exp_im[5] = 18'sd2;
        mem_re[6] = -30'sd2;  exp_re[6] = 18'sd0;   exp_im[6] = 18'sd1;
        mem_re[7] = 30'sd2;   exp_re[7] = 18'sd1;   exp_im[7] = 18'sd0;
        for (int k = 0; k < 8; k++) mem_im[k] = -mem_re[k];
        base = samp_re.size();
        start_run(12, 2);
        wait_done(0, 100, "round");
        check_samples(base, 12, "round");
        // shift = 0: saturation
        fill_zero();
        mem_re[0] = 30'sd1048576;   exp_re[0] = 18'sd131071;   exp_im[0] = -18'sd131072;
        mem_re[1] = -30'sd1048576;  exp_re[1] = -18'sd131072;  exp_im[1] = 18'sd131071;
        mem_re[2] = 30'sd131071;    exp_re[2] = 18'sd131071;   exp_im[2] = -18'sd131071;
        mem_re[3] = -30'sd131072;   exp_re[3] = -18'sd131072;  exp_im[3] = 18'sd131071;
        mem_re[4] = 30'sd131072;    exp_re[4] = 18'sd131071;   exp_im[4] = -18'sd131072;
        mem_re[5] = -30'sd131073;   exp_re[5] = -18'sd131072;  exp_im[5] = 18'sd131071;
        for (int k = 0; k < 6; k++) mem_im[k] = -mem_re[k];
        base = samp_re.size();
        start_run(12, 0);
        wait_done(0, 100, "sat");
        check_samples(base, 12, "sat");
        // shift = 12 near full scale: needs the extra guard bit
        fill_zero();
        mem_re[0] = 30'sd536870911;   exp_re[0] = 18'sd131071;
        mem_re[1] = -30'sd536870912;  exp_re[1] = -18'sd131072;
        mem_re[2] = 30'sd4096;        exp_re[2] = 18'sd1;
        mem_re[3] = 30'sd2048;        exp_re[3] = 18'sd1;
        mem_re[4] = 30'sd2047;        exp_re[4] = 18'sd0;
        mem_re[5] = -30'sd2048;       exp_re[5] = 18'sd0;
        mem_re[6] = -30'sd2049;       exp_re[6] = -18'sd1;
        base = samp_re.size();
        start_run(12, 12);
        wait_done(0, 100, "shift12");
        check_samples(base, 12, "shift12");
    endtask

    task automatic test_reset_midrun();
        int base;
        int c;
        int d0;
        fill_ramp();
        base = samp_re.size();
        out_ready = 1'b1;
        start_run(1200, 0);
        c = 0;
        while (samp_re.size() - base < 19 && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        n_cmp++;
        if (samp_re.size() - base < 19) begin
            n_fail++;
            $display("FAIL midrst_progress: got %0d samples, required 19", samp_re.size() - base);
        end
        d0  = done_cnt;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, out_sop, out_eop, busy, done, rden} !== 12'd0 || out_real !== 18'sd0 ||
            out_imag !== 18'sd0 || rdaddr !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got valid=%0b busy=%0b done=%0b rden=%b re=%0d, required all 0",
                     out_valid, busy, done, rden, out_real);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (done_cnt != d0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_quiet: got done_pulses=%0d busy=%0b valid=%0b, required 0 0 0",
                     done_cnt - d0, busy, out_valid);
        end
        base = samp_re.size();
        start_run(12, 0);
        wait_done(0, 100, "after_rst");
        check_samples(base, 12, "after_rst");
    endtask

    task automatic test_ignored_start();
        int base;
        int rbase;
        int d0;
        fill_ramp();
        base = samp_re.size();
        d0   = done_cnt;
        start_run(20, 0);
        repeat (4) @(posedge clk);
        #1;
        start  = 1'b1;
        dftpts = 12'd12;
        @(posedge clk); #1;
        start  = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_busy: got busy=%0b, required 1", busy);
        end
        wait_done(0, 200, "restart");
        check_samples(base, 20, "restart");
        n_cmp++;
        if (done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL restart_done_count: got %0d, required 1", done_cnt - d0);
        end
        base  = samp_re.size();
        rbase = rd_bank.size();
        d0    = done_cnt;
        start_run(0, 0);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_busy: got busy=%0b, required 0", busy);
        end
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        if (samp_re.size() != base || rd_bank.size() != rbase || done_cnt != d0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_ignored: got samples=%0d reads=%0d dones=%0d busy=%0b, required 0 0 0 0",
                     samp_re.size() - base, rd_bank.size() - rbase, done_cnt - d0, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_arith();
        test_reset_midrun();
        test_ignored_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
